// File: rtl/pic_fetch_unit.sv
// Fetch stage: program counter, instruction register and return stack.
// Resolves GOTO/CALL/RETURN/RETLW locally with a one-slot squash.
module pic_fetch_unit #(
    parameter int          STACK_DEPTH  = 16,
    parameter logic [10:0] RESET_VECTOR = 11'h000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [10:0] rom_addr,
    input  logic [13:0] rom_data,
    input  logic        stall,
    input  logic        exec_skip,
    output logic [13:0] ir,
    output logic        ir_valid,
    output logic [10:0] ir_pc,
    output logic [4:0]  stk_depth,
    output logic        stk_ovf,
    output logic        stk_unf
);

    localparam int         SPW  = $clog2(STACK_DEPTH);
    localparam logic [4:0] FULL = 5'(STACK_DEPTH);

    logic [10:0]    pc;
    logic [10:0]    pc_next;
    logic [SPW-1:0] sp;
    logic [SPW-1:0] sp_m1;
    logic [4:0]     depth;
    logic [10:0]    mem [STACK_DEPTH];
    logic [10:0]    top;

    logic is_goto;
    logic is_call;
    logic is_ret;
    logic is_retlw;
    logic jump;
    logic push;
    logic pop;
    logic take;
    logic skip;

    assign rom_addr  = pc;
    assign stk_depth = depth;
    assign sp_m1     = sp - SPW'(1);
    assign top       = mem[sp_m1];

    always_comb begin
        is_goto  = ir_valid && (ir[13:11] == 3'b101);
        is_call  = ir_valid && (ir[13:11] == 3'b100);
        is_ret   = ir_valid && (ir == 14'h0008);
        is_retlw = ir_valid && (ir[13:10] == 4'b1101);
        jump     = is_goto || is_call;
        push     = is_call;
        pop      = is_ret || is_retlw;
        take     = jump || pop;
        skip     = exec_skip && ir_valid && !take;
    end

    always_comb begin
        pc_next = pc + 11'd1;
        unique case (1'b1)
            pop:     pc_next = top;
            jump:    pc_next = ir[10:0];
            default: pc_next = pc + 11'd1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc       <= RESET_VECTOR;
            ir       <= 14'h0000;
            ir_valid <= 1'b0;
            ir_pc    <= 11'h000;
            sp       <= '0;
            depth    <= 5'd0;
            stk_ovf  <= 1'b0;
            stk_unf  <= 1'b0;
        end else if (!stall) begin
            pc <= pc_next;
            if (take || skip) begin
                ir       <= 14'h0000;
                ir_valid <= 1'b0;
            end else begin
                ir       <= rom_data;
                ir_valid <= 1'b1;
                ir_pc    <= pc;
            end
            // Full/empty stack keeps wrapping the pointer, depth saturates
            if (push) begin
                sp <= sp + SPW'(1);
                if (depth == FULL) stk_ovf <= 1'b1;
                else               depth   <= depth + 5'd1;
            end else if (pop) begin
                sp <= sp_m1;
                if (depth == 5'd0) stk_unf <= 1'b1;
                else               depth   <= depth - 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !stall && push)
            mem[sp] <= pc;
    end

endmodule

// File: tb/tb_pic_fetch_unit.sv
// Scoreboard bench for pic_fetch_unit: directed ROM images with
// hand-derived fetch traces (cycle, ir_pc, stack state).
module tb_pic_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] rom_addr;
    logic [13:0] rom_data;
    logic        stall = 1'b0;
    logic        exec_skip;
    logic [13:0] ir;
    logic        ir_valid;
    logic [10:0] ir_pc;
    logic [4:0]  stk_depth;
    logic        stk_ovf;
    logic        stk_unf;

    logic [13:0] rom [0:2047];
    bit          skip_en = 1'b0;
    bit          edge_stalled = 1'b0;
    int          cyc = 0;
    int          nvec = 0;
    int          nerr = 0;

    typedef struct {
        int          c;
        logic [10:0] pc;
        logic [13:0] ir;
        logic [4:0]  dep;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t sb [$];

    pic_fetch_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .stall     (stall),
        .exec_skip (exec_skip),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .ir_pc     (ir_pc),
        .stk_depth (stk_depth),
        .stk_ovf   (stk_ovf),
        .stk_unf   (stk_unf)
    );

    always #5 clk = ~clk;

    assign rom_data  = rom[rom_addr];
    assign exec_skip = skip_en && ir_valid && (ir == 14'h0BA4);

    always @(posedge clk) begin
        edge_stalled <= stall;
        cyc          <= rst_n ? cyc + 1 : 0;
    end

    // Monitor: one pop per newly presented valid instruction
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && !edge_stalled && ir_valid) begin
                nvec++;
                if (sb.size() == 0) begin
                    nerr++;
                    $display("FAIL sb_extra cyc %0d: got pc %h ir %h, want none",
                             cyc, ir_pc, ir);
                end else begin
                    e = sb.pop_front();
                    if (e.c != cyc || e.pc != ir_pc || e.ir != ir ||
                        e.dep != stk_depth || e.ovf != stk_ovf ||
                        e.unf != stk_unf) begin
                        nerr++;
                        $display({"FAIL sb cyc/pc/ir/dep/ovf/unf: got %0d %h %h %0d %b %b,",
                                  " want %0d %h %h %0d %b %b"},
                                 cyc, ir_pc, ir, stk_depth, stk_ovf, stk_unf,
                                 e.c, e.pc, e.ir, e.dep, e.ovf, e.unf);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int want);
        nvec++;
        if (act != want) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    task automatic exp_at(input int c, input int pc, input int dep,
                          input bit ovf, input bit unf);
        exp_t e;
        e.c   = c;
        e.pc  = 11'(pc);
        e.ir  = rom[11'(pc)];
        e.dep = 5'(dep);
        e.ovf = ovf;
        e.unf = unf;
        sb.push_back(e);
    endtask

    task automatic fill_rom();
        for (int i = 0; i < 2048; i++)
            rom[i] = 14'h1000 | 14'(i);
    endtask

    // Hold reset two edges, check reset state, release at a negedge
    task automatic do_reset();
        rst_n   = 1'b0;
        stall   = 1'b0;
        skip_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_ir", ir, 0);
        chk("rst_ir_valid", ir_valid, 0);
        chk("rst_ir_pc", ir_pc, 0);
        chk("rst_depth", stk_depth, 0);
        chk("rst_ovf", stk_ovf, 0);
        chk("rst_unf", stk_unf, 0);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_cyc(input int n);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (cyc == n) return;
        end
        nvec++;
        nerr++;
        $display("FAIL timeout waiting for cycle %0d: got %0d", n, cyc);
    endtask

    task automatic end_scn(input string nm, input int n);
        wait_cyc(n);
        #1 rst_n = 1'b0;
        chk({nm, "_sb_left"}, sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        // Straight-line fetch
        fill_rom();
        rom[0] = 14'h300F;
        rom[1] = 14'h00A4;
        rom[2] = 14'h01A5;
        rom[3] = 14'h0103;
        do_reset();
        for (int k = 1; k <= 4; k++)
            exp_at(k, k - 1, 0, 0, 0);
        wait_cyc(1);
        chk("seq_rom_addr_c1", rom_addr, 11'h001);
        end_scn("seq", 4);

        // GOTO 0x004 at 0x00A loops back
        fill_rom();
        rom[11'h00A] = 14'h2804;
        do_reset();
        for (int k = 1; k <= 11; k++)
            exp_at(k, k - 1, 0, 0, 0);
        for (int k = 13; k <= 19; k++)
            exp_at(k, k - 9, 0, 0, 0);
        exp_at(21, 4, 0, 0, 0);
        wait_cyc(12);
        chk("goto_bubble_valid", ir_valid, 0);
        chk("goto_target_addr", rom_addr, 11'h004);
        end_scn("goto", 21);

        // CALL 0x015 at 0x008, RETURN at 0x01F
        fill_rom();
        rom[11'h008] = 14'h2015;
        rom[11'h01F] = 14'h0008;
        do_reset();
        for (int k = 1; k <= 9; k++)
            exp_at(k, k - 1, 0, 0, 0);
        for (int k = 11; k <= 21; k++)
            exp_at(k, 'h15 + k - 11, 1, 0, 0);
        for (int k = 23; k <= 25; k++)
            exp_at(k, 9 + k - 23, 0, 0, 0);
        wait_cyc(10);
        chk("call_bubble_valid", ir_valid, 0);
        chk("call_depth", stk_depth, 1);
        wait_cyc(22);
        chk("ret_bubble_valid", ir_valid, 0);
        chk("ret_addr", rom_addr, 11'h009);
        end_scn("call", 25);

        // DECFSZ at 0x012 with skip taken
        fill_rom();
        rom[11'h012] = 14'h0BA4;
        do_reset();
        skip_en = 1'b1;
        for (int k = 1; k <= 19; k++)
            exp_at(k, k - 1, 0, 0, 0);
        exp_at(21, 'h14, 0, 0, 0);
        exp_at(22, 'h15, 0, 0, 0);
        end_scn("skip1", 22);

        // Same image, skip not taken
        do_reset();
        for (int k = 1; k <= 22; k++)
            exp_at(k, k - 1, 0, 0, 0);
        end_scn("skip0", 22);

        // 17 nested CALLs then 17 RETURNs
        fill_rom();
        rom[0] = 14'h2900;
        for (int i = 0; i <= 16; i++) begin
            rom['h100 + 2 * i] = 14'h2000 | 14'('h102 + 2 * i);
            rom['h101 + 2 * i] = 14'h0008;
        end
        rom['h122] = 14'h0008;
        do_reset();
        exp_at(1, 0, 0, 0, 0);
        for (int i = 1; i <= 17; i++)
            exp_at(1 + 2 * i, 'h100 + 2 * (i - 1), i - 1, 0, 0);
        for (int j = 1; j <= 17; j++)
            exp_at(35 + 2 * j, (j == 1) ? 'h122 : 'h121 - 2 * (j - 2),
                   17 - j, 1, 0);
        exp_at(71, 'h121, 0, 1, 1);
        end_scn("stack", 71);

        // Stall three cycles with GOTO in ir
        fill_rom();
        rom[11'h00A] = 14'h2804;
        do_reset();
        for (int k = 1; k <= 11; k++)
            exp_at(k, k - 1, 0, 0, 0);
        exp_at(16, 4, 0, 0, 0);
        exp_at(17, 5, 0, 0, 0);
        wait_cyc(11);
        #1 stall = 1'b1;
        for (int k = 12; k <= 14; k++) begin
            wait_cyc(k);
            chk("stall_ir", ir, 14'h2804);
            chk("stall_ir_pc", ir_pc, 11'h00A);
            chk("stall_rom_addr", rom_addr, 11'h00B);
        end
        #1 stall = 1'b0;
        wait_cyc(15);
        chk("unstall_valid", ir_valid, 0);
        chk("unstall_addr", rom_addr, 11'h004);
        end_scn("stall", 17);

        // PC wrap 0x7FF -> 0x000
        fill_rom();
        rom[0] = 14'h2FFE;
        do_reset();
        exp_at(1, 0, 0, 0, 0);
        exp_at(3, 'h7FE, 0, 0, 0);
        exp_at(4, 'h7FF, 0, 0, 0);
        exp_at(5, 0, 0, 0, 0);
        wait_cyc(4);
        chk("wrap_rom_addr", rom_addr, 11'h000);
        end_scn("wrap", 5);

        do_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
